// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared types and constants for the PS/2 keymap decoder
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GOT_E0,
        ST_GOT_F0,
        ST_GOT_E0F0
    } ps2_state_t;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

    // Slot order: 0=W/up, 1=S/down, 2=A/left, 3=D/right
    localparam logic [7:0] PS2_CODE_W = 8'h1D;
    localparam logic [7:0] PS2_CODE_S = 8'h1B;
    localparam logic [7:0] PS2_CODE_A = 8'h1C;
    localparam logic [7:0] PS2_CODE_D = 8'h23;

    localparam logic [7:0] PS2_ASCII_W = 8'd87;
    localparam logic [7:0] PS2_ASCII_S = 8'd83;
    localparam logic [7:0] PS2_ASCII_A = 8'd65;
    localparam logic [7:0] PS2_ASCII_D = 8'd68;

    localparam logic [31:0] PS2_WASD_CODES = {PS2_CODE_D, PS2_CODE_A, PS2_CODE_S, PS2_CODE_W};
    localparam logic [31:0] PS2_WASD_ASCII = {PS2_ASCII_D, PS2_ASCII_A, PS2_ASCII_S, PS2_ASCII_W};

    // Extended (E0-prefixed) arrow codes aliasing slots 0-3
    localparam logic [7:0] PS2_EXT_UP    = 8'h75;
    localparam logic [7:0] PS2_EXT_DOWN  = 8'h72;
    localparam logic [7:0] PS2_EXT_LEFT  = 8'h6B;
    localparam logic [7:0] PS2_EXT_RIGHT = 8'h74;

    localparam logic [31:0] PS2_ARROW_CODES = {PS2_EXT_RIGHT, PS2_EXT_LEFT, PS2_EXT_DOWN, PS2_EXT_UP};

    typedef struct packed {
        logic       make;
        logic [7:0] ascii;
    } ps2_event_t;

endpackage

// File: rtl/ps2_event_fifo.sv
// rtl/ps2_event_fifo.sv - first-word fall-through event FIFO with sticky overflow
module ps2_event_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     inclock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [8:0]               push_data,
    input  logic                     pop,
    output logic [8:0]               head_data,
    output logic                     valid,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [8:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          pop_fire;
    logic          push_fire;
    logic          drop;

    assign valid     = (count != '0);
    assign full      = (count == (AW+1)'(DEPTH));
    assign head_data = mem[rd_ptr];

    // A same-cycle pop frees the slot, so a push into a full FIFO still lands
    assign pop_fire  = pop && valid;
    assign push_fire = push && (!full || pop_fire);
    assign drop      = push && full && !pop_fire;

    // Storage write; contents need no reset since count gates visibility
    always_ff @(posedge inclock) begin
        if (push_fire) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers, occupancy and sticky overflow
    always_ff @(posedge inclock) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_fire) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_fire) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_fire, pop_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_keymap_decoder.sv
// rtl/ps2_keymap_decoder.sv - PS/2 set-2 parser, held-key bitmap and event queue; PS2_EXT_KEYS_EN adds arrow aliases
module ps2_keymap_decoder
    import ps2_pkg::*;
#(
    parameter int                    NUM_KEYS       = 4,
    parameter logic [NUM_KEYS*8-1:0] KEY_CODES      = PS2_WASD_CODES,
    parameter logic [NUM_KEYS*8-1:0] KEY_ASCII      = PS2_WASD_ASCII,
    parameter int                    FIFO_DEPTH     = 8,
    parameter int                    TIMEOUT_CYCLES = 2_500_000
) (
    input  logic                          inclock,
    input  logic                          reset,
    input  logic [7:0]                    rx_data,
    input  logic                          rx_valid,
    output logic [NUM_KEYS-1:0]           key_held,
    output logic                          any_held,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic                          evt_make,
    output logic [7:0]                    evt_ascii,
    output logic [$clog2(FIFO_DEPTH):0]   evt_count,
    output logic                          overflow,
    output logic [7:0]                    last_ascii
);

    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    ps2_state_t    state;
    ps2_state_t    state_nxt;
    logic [TMO_W-1:0] tmo_cnt;
    logic          tmo_hit;

    logic          resolve;
    logic          res_ext;
    logic          res_brk;

    logic          hit;
    logic [NUM_KEYS-1:0] hit_oh;
    logic [7:0]    hit_ascii;
    logic          hit_held;

    logic          do_press;
    logic          do_release;
    ps2_event_t    push_evt;
    ps2_event_t    head_evt;
    logic [8:0]    head_data;
    logic          fifo_full;

    assign tmo_hit = (state != ST_IDLE) && !rx_valid &&
                     (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    // Parser state register
    always_ff @(posedge inclock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Prefix abandonment counter: runs only while a sequence is half-received
    always_ff @(posedge inclock) begin
        if (reset || state == ST_IDLE || rx_valid || tmo_hit) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // Next-state and resolve strobes; the final byte of a sequence fires resolve
    always_comb begin
        state_nxt = state;
        resolve   = 1'b0;
        res_ext   = 1'b0;
        res_brk   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rx_valid) begin
                    if (rx_data == PS2_PREFIX_EXT) begin
                        state_nxt = ST_GOT_E0;
                    end else if (rx_data == PS2_PREFIX_BRK) begin
                        state_nxt = ST_GOT_F0;
                    end else begin
                        resolve = 1'b1;
                    end
                end
            end
            ST_GOT_E0: begin
                if (rx_valid) begin
                    if (rx_data == PS2_PREFIX_BRK) begin
                        state_nxt = ST_GOT_E0F0;
                    end else begin
                        resolve   = 1'b1;
                        res_ext   = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end else if (tmo_hit) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_GOT_F0: begin
                if (rx_valid) begin
                    resolve   = 1'b1;
                    res_brk   = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (tmo_hit) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_GOT_E0F0: begin
                if (rx_valid) begin
                    resolve   = 1'b1;
                    res_ext   = 1'b1;
                    res_brk   = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (tmo_hit) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Slot lookup; scanning from the top down leaves the lowest matching slot as winner
    always_comb begin
        hit       = 1'b0;
        hit_oh    = '0;
        hit_ascii = 8'h00;
        hit_held  = 1'b0;
        if (resolve && !res_ext) begin
            for (int i = NUM_KEYS - 1; i >= 0; i--) begin
                if (rx_data == KEY_CODES[i*8 +: 8]) begin
                    hit       = 1'b1;
                    hit_oh    = '0;
                    hit_oh[i] = 1'b1;
                    hit_ascii = KEY_ASCII[i*8 +: 8];
                    hit_held  = key_held[i];
                end
            end
        end
`ifdef PS2_EXT_KEYS_EN
        if (resolve && res_ext) begin
            for (int i = 3; i >= 0; i--) begin
                if (rx_data == PS2_ARROW_CODES[i*8 +: 8]) begin
                    hit       = 1'b1;
                    hit_oh    = '0;
                    hit_oh[i] = 1'b1;
                    hit_ascii = KEY_ASCII[i*8 +: 8];
                    hit_held  = key_held[i];
                end
            end
        end
`endif
    end

    // Typematic repeats and breaks of unheld keys fall out as no-ops here
    assign do_press      = hit && !res_brk && !hit_held;
    assign do_release    = hit && res_brk && hit_held;
    assign push_evt.make  = do_press;
    assign push_evt.ascii = hit_ascii;

    // Held-key bitmap and last accepted press
    always_ff @(posedge inclock) begin
        if (reset) begin
            key_held   <= '0;
            last_ascii <= 8'h00;
        end else begin
            if (do_press) begin
                key_held   <= key_held | hit_oh;
                last_ascii <= hit_ascii;
            end else if (do_release) begin
                key_held <= key_held & ~hit_oh;
            end
        end
    end

    assign any_held = |key_held;

    ps2_event_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .inclock   (inclock),
        .reset     (reset),
        .push      (do_press || do_release),
        .push_data (push_evt),
        .pop       (evt_ready),
        .head_data (head_data),
        .valid     (evt_valid),
        .full      (fifo_full),
        .count     (evt_count),
        .overflow  (overflow)
    );

    assign head_evt  = ps2_event_t'(head_data);
    assign evt_make  = head_evt.make;
    assign evt_ascii = head_evt.ascii;

endmodule
